// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit types: buffered fetch entry, decoded field view and FSM states.
package types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } FetchEntry;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } InstructionDetails;

  typedef enum logic {
    RUN,
    FLUSH
  } FetchState;

  function automatic InstructionDetails decodeFields(input logic [31:0] word);
    return InstructionDetails'(word);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with synchronous flush; head data reads as zero while empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             rst_async,
  input  logic             clk,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_headData,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_doPop    = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_doPush   = i_push && (!w_full || w_doPop);
  assign o_count    = r_count;
  assign o_headData = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop) r_rdPtr <= nextPtr(r_rdPtr);
      if (w_doPush && !w_doPop) r_count <= r_count + 1'b1;
      else if (!w_doPush && w_doPop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-paced requests, in-order PC queue, redirect with response dropping.
// Optional FETCH_TRACE_EN macro prints one line per buffer pop and per redirect.
module fetch_unit
  import types::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        rst_async,
  input  logic        clk,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] BUDGET = (CW + 1)'(FIFO_DEPTH);

  FetchState   r_state;
  FetchState   w_stateNext;
  logic [31:0] r_fetchPc;
  logic [CW-1:0] r_dropCount;
  logic [CW-1:0] w_dropNext;
  logic [CW-1:0] w_pcqCount;
  logic [CW-1:0] w_bufCount;
  logic        w_pcqEmpty;
  logic        w_bufEmpty;
  logic [31:0] w_rspPc;
  FetchEntry   w_head;
  FetchEntry   w_pushEntry;
  logic        w_inBudget;
  logic        w_accept;
  logic        w_rspTaken;
  logic        w_rspKeep;
  logic        w_pop;

  // Outstanding requests plus buffered entries never exceed the buffer depth.
  assign w_inBudget     = ({1'b0, w_pcqCount} + {1'b0, w_bufCount}) < BUDGET;
  assign imem_req_valid = !rst_async && !redirect_valid && w_inBudget;
  assign imem_req_addr  = r_fetchPc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_rspTaken     = imem_rsp_valid && !w_pcqEmpty;
  assign w_rspKeep      = w_rspTaken && (r_state == RUN) && !redirect_valid;
  assign w_pop          = !w_bufEmpty && !stall && !redirect_valid;
  assign w_pushEntry    = '{instruction: imem_rsp_data, pc: w_rspPc};

  assign instruction = w_head.instruction;
  assign instr_pc    = w_head.pc;
  assign instr_valid = !w_bufEmpty;

  always_comb begin
    w_dropNext  = r_dropCount;
    w_stateNext = r_state;
    if (redirect_valid) begin
      w_dropNext  = w_pcqCount - CW'(w_rspTaken);
      w_stateNext = (w_dropNext != '0) ? FLUSH : RUN;
    end else if (w_rspTaken && (r_dropCount != '0)) begin
      w_dropNext = r_dropCount - 1'b1;
      if (w_dropNext == '0) w_stateNext = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state     <= RUN;
      r_fetchPc   <= RESET_PC;
      r_dropCount <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_dropCount <= w_dropNext;
      if (redirect_valid) r_fetchPc <= redirect_pc;
      else if (w_accept) r_fetchPc <= r_fetchPc + 32'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .WIDTH($bits(FetchEntry)),
    .DEPTH(FIFO_DEPTH)
  ) u_instrBuf (
    .rst_async (rst_async),
    .clk       (clk),
    .i_flush   (redirect_valid),
    .i_push    (w_rspKeep),
    .i_pushData(w_pushEntry),
    .i_pop     (w_pop),
    .o_headData(w_head),
    .o_count   (w_bufCount),
    .o_empty   (w_bufEmpty)
  );

  // The PC queue is never flushed: dropped responses still retire their PC in order.
  fetch_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_pcQueue (
    .rst_async (rst_async),
    .clk       (clk),
    .i_flush   (1'b0),
    .i_push    (w_accept),
    .i_pushData(r_fetchPc),
    .i_pop     (w_rspTaken),
    .o_headData(w_rspPc),
    .o_count   (w_pcqCount),
    .o_empty   (w_pcqEmpty)
  );

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst_async && w_pop) $display("FETCH pc=%h instr=%h", w_head.pc, w_head.instruction);
    if (!rst_async && redirect_valid) $display("FETCH redirect pc=%h drop=%0d", redirect_pc, w_dropNext);
  end
`else
  // Tracing compiled out; cycle behaviour is identical.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model and a simple in-order memory.
module tb_fetch_unit;
  import types::*;

  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_async = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;

  int vectors = 0;
  int miscompares = 0;
  bit rspEnable = 1'b1;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .rst_async     (rst_async),
    .clk           (clk),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address so every word is distinct.
  function automatic logic [31:0] memData(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ {addr[15:0], addr[31:16]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit st, input bit rdy, input bit ren);
    @(posedge clk);
    #1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    imem_req_ready = rdy;
    rspEnable      = ren;
  endtask

  // In-order memory: answers each accepted request one cycle later while rspEnable is set.
  logic [31:0] memQ[$];
  bit          memAccept;
  bit          memRspFire;
  logic [31:0] memAddr;

  always @(negedge clk) begin
    memAccept  = imem_req_valid && imem_req_ready;
    memAddr    = imem_req_addr;
    memRspFire = imem_rsp_valid;
  end

  always @(posedge clk) begin
    #2;
    if (rst_async) begin
      memQ.delete();
    end else begin
      if (memRspFire && memQ.size() > 0) void'(memQ.pop_front());
      if (memAccept) memQ.push_back(memAddr);
    end
    imem_rsp_valid = !rst_async && rspEnable && (memQ.size() > 0);
    imem_rsp_data  = (memQ.size() > 0) ? memData(memQ[0]) : 32'h0;
  end

  // Reference model: pending requests tagged live/dropped, and the buffered entries the decoder should see.
  typedef struct {
    logic [31:0] addr;
    bit          live;
  } PendReq;

  PendReq      mPend[$];
  FetchEntry   mBuf[$];
  logic [31:0] mFetchPc = 32'h0;
  bit          mExpReq;
  bit          mRsp;
  bit          mLive;
  logic [31:0] mRspAddr;

  always @(negedge clk) begin
    if (rst_async) begin
      checkOutput("rstReqValid", 32'(imem_req_valid), 32'd0);
      checkOutput("rstInstrValid", 32'(instr_valid), 32'd0);
      checkOutput("rstInstruction", instruction, 32'd0);
      checkOutput("rstInstrPc", instr_pc, 32'd0);
      mFetchPc = 32'h0;
      mPend.delete();
      mBuf.delete();
    end else begin
      mExpReq = !redirect_valid && ((mPend.size() + mBuf.size()) < FIFO_DEPTH);
      checkOutput("reqValid", 32'(imem_req_valid), 32'(mExpReq));
      if (mExpReq) checkOutput("reqAddr", imem_req_addr, mFetchPc);
      checkOutput("instrValid", 32'(instr_valid), 32'(mBuf.size() > 0));
      if (mBuf.size() > 0) begin
        checkOutput("instrPc", instr_pc, mBuf[0].pc);
        checkOutput("instruction", instruction, mBuf[0].instruction);
      end
      mRsp     = imem_rsp_valid && (mPend.size() > 0);
      mLive    = 1'b0;
      mRspAddr = 32'h0;
      if (mRsp) begin
        mLive    = mPend[0].live;
        mRspAddr = mPend[0].addr;
        void'(mPend.pop_front());
      end
      if (redirect_valid) begin
        mBuf.delete();
        foreach (mPend[i]) mPend[i].live = 1'b0;
        mFetchPc = redirect_pc;
      end else begin
        if (mBuf.size() > 0 && !stall) void'(mBuf.pop_front());
        if (mRsp && mLive) mBuf.push_back('{instruction: memData(mRspAddr), pc: mRspAddr});
        if (mExpReq && imem_req_ready) begin
          mPend.push_back('{addr: mFetchPc, live: 1'b1});
          mFetchPc = mFetchPc + 32'd4;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    int firstValid;
    int popCount;
    logic [31:0] pcs[3];
    logic [31:0] heldPc;
    logic [31:0] prevPc;
    logic [31:0] addr0;
    int accepts;
    int breaks;
    int stale;
    int okCnt;
    bit found;
    bit sawFirst;

    // Reset release, always-ready memory, one-cycle responses.
    repeat (3) @(posedge clk);
    #1 rst_async = 1'b0;
    firstValid = 0;
    popCount = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("firstReqValid", 32'(imem_req_valid), 32'd1);
        checkOutput("firstReqAddr", imem_req_addr, 32'h0);
      end
      if (instr_valid && firstValid == 0) firstValid = c;
      if (instr_valid && !stall && popCount < 3) begin
        pcs[popCount] = instr_pc;
        popCount++;
      end
    end
    checkOutput("firstInstrValidCycle", 32'(firstValid), 32'd3);
    checkOutput("pcSeq0", pcs[0], 32'h0);
    checkOutput("pcSeq1", pcs[1], 32'h4);
    checkOutput("pcSeq2", pcs[2], 32'h8);

    // Stall held for ten cycles.
    applyStimulus(0, 32'h0, 1, 1, 1);
    accepts = 0;
    heldPc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) accepts++;
      if (i == 9) begin
        checkOutput("stallReqIdle", 32'(imem_req_valid), 32'd0);
        checkOutput("stallInstrValid", 32'(instr_valid), 32'd1);
        heldPc = instr_pc;
      end
    end
    checkOutput("stallAcceptsBounded", 32'(accepts <= FIFO_DEPTH), 32'd1);
    applyStimulus(0, 32'h0, 0, 1, 1);
    popCount = 0;
    breaks = 0;
    prevPc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        if (popCount == 0) checkOutput("firstPopAfterStall", instr_pc, heldPc);
        else if (instr_pc != prevPc + 32'd4) breaks++;
        prevPc = instr_pc;
        popCount++;
      end
    end
    checkOutput("noEntryLost", 32'(breaks), 32'd0);
    checkOutput("popsAfterStall", 32'(popCount >= 4), 32'd1);

    // Redirect to 0x100 with requests 0x8 and 0xC outstanding.
    applyStimulus(1, 32'h8, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_addr == 32'h8) found = 1'b1;
    end
    checkOutput("waitReq8", 32'(found), 32'd1);
    applyStimulus(0, 32'h0, 0, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (!imem_req_valid && !instr_valid) found = 1'b1;
    end
    checkOutput("waitTwoOutstanding", 32'(found), 32'd1);
    checkOutput("outstandingCount", 32'(memQ.size()), 32'd2);
    applyStimulus(1, 32'h100, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);
    stale = 0;
    sawFirst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        if (instr_pc == 32'h8 || instr_pc == 32'hC) stale++;
        if (!sawFirst) begin
          checkOutput("pcAfterRedirect", instr_pc, 32'h100);
          checkOutput("dataAfterRedirect", instruction, memData(32'h100));
          sawFirst = 1'b1;
        end
      end
    end
    checkOutput("sawRedirectTarget", 32'(sawFirst), 32'd1);
    checkOutput("noStaleVisible", 32'(stale), 32'd0);

    // Address wrap at the top of the address space.
    applyStimulus(1, 32'hFFFF_FFFC, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'hFFFF_FFFC) found = 1'b1;
    end
    checkOutput("waitTopAddr", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        found = 1'b1;
        checkOutput("wrapAddr", imem_req_addr, 32'h0);
      end
    end
    checkOutput("waitWrapReq", 32'(found), 32'd1);

    // Memory not ready for five cycles, then redirect while waiting.
    applyStimulus(0, 32'h0, 0, 0, 1);
    repeat (4) @(negedge clk);
    okCnt = 0;
    addr0 = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_addr == addr0) okCnt++;
    end
    checkOutput("addrHeldWhileWaiting", 32'(okCnt), 32'd5);
    applyStimulus(1, 32'h200, 0, 0, 1);
    @(negedge clk);
    checkOutput("redirectCycleNoReq", 32'(imem_req_valid), 32'd0);
    applyStimulus(0, 32'h0, 0, 0, 1);
    @(negedge clk);
    checkOutput("reqAfterRedirectValid", 32'(imem_req_valid), 32'd1);
    checkOutput("reqAfterRedirectAddr", imem_req_addr, 32'h200);
    applyStimulus(0, 32'h0, 0, 1, 1);
    repeat (8) @(negedge clk);

    // Reset pulsed while dropping responses.
    applyStimulus(0, 32'h0, 0, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!imem_req_valid && !instr_valid) found = 1'b1;
    end
    checkOutput("waitFlushSetup", 32'(found), 32'd1);
    applyStimulus(1, 32'h300, 0, 1, 0);
    applyStimulus(0, 32'h0, 0, 1, 0);
    @(posedge clk);
    #1 rst_async = 1'b1;
    #1;
    checkOutput("asyncRstReqValid", 32'(imem_req_valid), 32'd0);
    checkOutput("asyncRstInstrValid", 32'(instr_valid), 32'd0);
    checkOutput("asyncRstInstruction", instruction, 32'd0);
    checkOutput("asyncRstInstrPc", instr_pc, 32'd0);
    applyStimulus(0, 32'h0, 0, 1, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);
    @(posedge clk);
    #1 rst_async = 1'b0;
    @(negedge clk);
    checkOutput("resumeReqValid", 32'(imem_req_valid), 32'd1);
    checkOutput("resumeReqAddr", imem_req_addr, 32'h0);
    sawFirst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_valid && !sawFirst) begin
        checkOutput("resumeFirstPc", instr_pc, 32'h0);
        sawFirst = 1'b1;
      end
    end
    checkOutput("resumeSawInstr", 32'(sawFirst), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, 2, instruction buffer entries and maximum in-flight credit (range 2..4).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: port rst_async (input, 1) is the reset and port clk (input, 1) is the clock; rst_async is listed first and clk second.
REQ-004 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-005 SHALL have port redirect_pc, input, 32, redirect target (word-aligned).
REQ-006 SHALL have port stall, input, 1, downstream decoder not accepting.
REQ-007 SHALL have port imem_req_valid, output, 1, memory read request.
REQ-008 SHALL have port imem_req_addr, output, 32, request byte address.
REQ-009 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-010 SHALL have port imem_rsp_valid, input, 1, read data valid (in order, at least 1 cycle after accept).
REQ-011 SHALL have port imem_rsp_data, input, 32, read data.
REQ-012 SHALL have port instruction, output, 32, instruction word to decoder.
REQ-013 SHALL have port instr_valid, output, 1, instruction holds a live entry.
REQ-014 SHALL have port instr_pc, output, 32, address of instruction.

Function
REQ-015 SHALL keep fetch_pc; a request is accepted when imem_req_valid && imem_req_ready, then fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-016 SHALL assert imem_req_valid only when outstanding + fifo_count < FIFO_DEPTH, so the FIFO can never overflow.
REQ-017 SHALL hold imem_req_addr = fetch_pc stable while imem_req_valid is high and not accepted, unless a redirect occurs.
REQ-018 SHALL push {imem_rsp_data, pc} into the FIFO on each non-dropped response; pc comes from an internal in-order PC queue.
REQ-019 SHALL drive instruction/instr_pc from the FIFO head, and instr_valid = FIFO non-empty.
REQ-020 SHALL pop the head when instr_valid && !stall; a push and pop in the same cycle with the FIFO full SHALL be legal, with count unchanged.
REQ-021 SHALL give redirect_valid priority over all other events in its cycle, with these effects:
- FIFO flushed and instr_valid = 0 in the next cycle;
- fetch_pc <= redirect_pc;
- drop_count <= outstanding, counting a request accepted in the same cycle;
- imem_req_valid forced 0 that cycle.
REQ-022 SHALL discard responses while drop_count > 0, decrementing it per response; discarded data never reaches instruction.
REQ-023 SHALL implement the FSM RUN / FLUSH:
- RUN -> FLUSH on redirect with outstanding > 0;
- FLUSH -> RUN when drop_count reaches 0;
- new requests are allowed in FLUSH under REQ-016, and their responses follow the dropped ones.
REQ-024 SHALL make the redirect-to-first-new-request latency 1 cycle, and first instr_valid no earlier than response cycle + 1.
REQ-025 SHALL treat a redirect during FLUSH as adding new outstanding requests to drop_count.

Reset
REQ-026 SHALL, on rst_async high, set these values immediately (asynchronous):
- fetch_pc = RESET_PC, FSM = RUN;
- FIFO, PC queue, outstanding and drop_count = 0;
- imem_req_valid = 0, instr_valid = 0, instruction = 0, instr_pc = 0.
REQ-027 SHALL ignore responses arriving after reset release for requests issued before reset; the memory is reset alongside.
REQ-028 SHALL issue the first request at the first clk edge after reset release.

Configuration
REQ-029 SHALL, with FETCH_TRACE_EN defined, print one $display line per FIFO pop: "FETCH pc=<hex> instr=<hex>", plus one per redirect: "FETCH redirect pc=<hex> drop=<d>".
REQ-030 SHALL, without FETCH_TRACE_EN, contain no $display, with identical cycle behaviour.

Structure
REQ-031 SHALL place RESET_PC default, INSTR_BYTES = 4 and a FetchEntry typedef {instruction, pc} in package types, alongside InstructionDetails.
REQ-032 SHALL implement the FIFO as sub-module fetch_fifo, used for both the instruction buffer and the PC queue.

Verification
REQ-033 SHALL cover: reset release, memory always ready, 1-cycle responses -> instr_pc sequence 0x0, 0x4, 0x8, and instr_valid first high at cycle 3.
REQ-034 SHALL cover: stall held high 10 cycles -> at most FIFO_DEPTH requests accepted, then imem_req_valid = 0; no entry lost after stall drops.
REQ-035 SHALL cover: redirect to 0x100 with 2 outstanding -> two responses discarded; next instr_pc = 0x100, with no 0x8/0xC data visible.
REQ-036 SHALL cover: fetch_pc = 0xFFFF_FFFC -> next request addr 0x0.
REQ-037 SHALL cover: imem_req_ready low 5 cycles -> imem_req_addr constant; a redirect mid-wait changes addr to redirect_pc next cycle.
REQ-038 SHALL cover: rst_async pulsed mid-FLUSH -> all outputs at reset values within the same cycle; fetch resumes at RESET_PC.
